// File: rtl/console_capture.sv
// console_capture
//   Snoops the CPU native memory bus for byte writes to CONSOLE_ADDR and queues each
//   character together with the 40-bit cycle timestamp of the capturing cycle. Queued
//   characters are presented first-word-fall-through on print_out, one per handshake.
//   The snoop never stalls the CPU: a capture into a full FIFO with no pop is dropped
//   and counted.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   mem_valid     CPU bus request valid
//   mem_ready     memory completes the request this cycle
//   mem_addr      CPU bus address
//   mem_wdata     CPU write data; character is [7:0]
//   mem_wstrb     byte strobes; 0 means read
//   print_out     {valid[48], timestamp[47:8], char[7:0]}; payload is 0 while invalid
//   print_ready   consumer accepts the head entry while print_out[48] is set
//   fifo_level    entries held, 0..DEPTH
//   overflow_cnt  characters dropped because the FIFO was full; saturates at 16'hFFFF

module console_capture #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_valid,
    input  logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [48:0]   print_out,
    input  logic          print_ready,
    output logic [AW:0]   fifo_level,
    output logic [15:0]   overflow_cnt
);

    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [39:0]   ts_q;
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [15:0]   ovf_q;

    logic cap;
    logic full;
    logic valid;
    logic pop;
    logic push;

    assign cap   = mem_valid & mem_ready & mem_wstrb[0] & (mem_addr == CONSOLE_ADDR);
    assign full  = (level_q == FullLevel);
    assign valid = (level_q != '0);
    assign pop   = valid & print_ready;
    // A pop in the same cycle frees the slot the new character lands in.
    assign push  = cap & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            ts_q <= ts_q + 40'd1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (cap && full && !pop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: the payload is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {ts_q, mem_wdata[7:0]};
        end
    end

    // Output derives only from registers, so an async reset drops valid immediately.
    always_comb begin
        print_out = '0;
        if (valid) begin
            print_out = {1'b1, mem[rd_ptr_q]};
        end
    end

    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;

endmodule
